// File: rtl/ft245_sync_tx_if.sv
// Handshake and FTDI pad bundle between the response master, the TX engine and the FT245 pins.
// The slave side is the TX engine; the master side is everything around it.
interface ft245_sync_tx_if #(
  parameter int COUNT_WIDTH = 24
);
  logic                   start;
  logic [31:0]            status;
  logic [31:0]            address;
  logic [COUNT_WIDTH-1:0] data_count;
  logic                   busy;
  logic                   done;
  logic [31:0]            data_in;
  logic                   data_valid;
  logic                   data_ready;
  logic                   rx_active;
  logic                   ftdi_txe_n;
  logic                   ftdi_wr_n;
  logic [7:0]             ftdi_data_out;
  logic                   ftdi_data_oe;
  logic                   ftdi_siwu;

  modport slave (
    input  start, status, address, data_count, data_in, data_valid, rx_active, ftdi_txe_n,
    output busy, done, data_ready, ftdi_wr_n, ftdi_data_out, ftdi_data_oe, ftdi_siwu
  );

  modport master (
    output start, status, address, data_count, data_in, data_valid, rx_active, ftdi_txe_n,
    input  busy, done, data_ready, ftdi_wr_n, ftdi_data_out, ftdi_data_oe, ftdi_siwu
  );
endinterface

// File: rtl/ft245_sync_tx.sv
// FT245 synchronous-FIFO transmit engine: serialises status, address and N payload words
// MSB byte first onto the shared FTDI bus, with a one-word prefetch to avoid inter-word bubbles.
module ft245_sync_tx #(
  parameter int COUNT_WIDTH    = 24,
  parameter bit SEND_IMMEDIATE = 1'b1
) (
  input  logic           ftdi_clk,
  input  logic           rst,
  ft245_sync_tx_if.slave bus
);
  localparam int WL_W = COUNT_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_SEND, S_STALL, S_FLUSH, S_DONE
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [31:0]            r_shift, r_nxt;
  logic                   r_nxt_vld;
  logic [1:0]             r_byte_cnt;
  logic [WL_W-1:0]        r_words_left;
  logic [COUNT_WIDTH-1:0] r_fetch_left;
  logic                   r_wr_n, r_data_oe, r_siwu, r_done;

  logic                   w_start, w_accept, w_last_byte, w_last_word, w_word_end;
  logic                   w_reload, w_stall_load, w_xfer, w_data_ready;
  logic [COUNT_WIDTH-1:0] w_n;

  assign w_start      = (r_state == S_IDLE) && bus.start;
  assign w_accept     = (r_state == S_SEND) && !r_wr_n && !bus.ftdi_txe_n;
  assign w_last_byte  = (r_byte_cnt == 2'd3);
  assign w_last_word  = (r_words_left == WL_W'(1));
  assign w_word_end   = w_accept && w_last_byte && !w_last_word;
  assign w_reload     = w_word_end && r_nxt_vld;
  assign w_stall_load = (r_state == S_STALL) && r_nxt_vld;
  assign w_data_ready = ((r_state == S_SEND) || (r_state == S_STALL)) && !r_nxt_vld
                        && (r_fetch_left != '0);
  assign w_xfer       = bus.data_valid && w_data_ready;
  assign w_n          = (bus.data_count == '0) ? COUNT_WIDTH'(1) : bus.data_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.start) w_state_nxt = S_WAIT_BUS;
      S_WAIT_BUS: if (!bus.rx_active) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_accept && w_last_byte) begin
          if (w_last_word)     w_state_nxt = S_FLUSH;
          else if (!r_nxt_vld) w_state_nxt = S_STALL;
        end
      end
      S_STALL:    if (r_nxt_vld) w_state_nxt = S_SEND;
      S_FLUSH:    w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Pad strobes are registered from the next state so they change on the edge that enters it.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_n       <= 1'b1;
      r_data_oe    <= 1'b0;
      r_siwu       <= 1'b1;
      r_done       <= 1'b0;
      r_nxt_vld    <= 1'b0;
      r_byte_cnt   <= '0;
      r_words_left <= '0;
      r_fetch_left <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_n    <= !((r_state == S_SEND) && (w_state_nxt == S_SEND) && !bus.ftdi_txe_n);
      r_data_oe <= (w_state_nxt == S_SEND) || (w_state_nxt == S_STALL);
      r_siwu    <= !(SEND_IMMEDIATE && (w_state_nxt == S_FLUSH));
      r_done    <= (w_state_nxt == S_DONE);
      if (w_start) begin
        r_nxt_vld    <= 1'b1;
        r_byte_cnt   <= '0;
        r_fetch_left <= w_n;
        r_words_left <= {2'b00, w_n} + WL_W'(2);
      end else begin
        if (w_accept && !w_last_byte) r_byte_cnt <= r_byte_cnt + 2'd1;
        if (w_word_end) begin
          r_words_left <= r_words_left - WL_W'(1);
          r_byte_cnt   <= '0;
        end
        if (w_reload || w_stall_load) r_nxt_vld <= 1'b0;
        // A fresh payload word always wins over the consume of the previous one.
        if (w_xfer) begin
          r_nxt_vld    <= 1'b1;
          r_fetch_left <= r_fetch_left - COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (w_start) begin
      r_shift <= bus.status;
      r_nxt   <= bus.address;
    end else begin
      if (w_accept && !w_last_byte)   r_shift <= {r_shift[23:0], 8'h00};
      if (w_reload || w_stall_load)   r_shift <= r_nxt;
      if (w_xfer)                     r_nxt   <= bus.data_in;
    end
  end

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = r_done;
  assign bus.data_ready    = w_data_ready;
  assign bus.ftdi_wr_n     = r_wr_n;
  assign bus.ftdi_data_out = r_shift[31:24];
  assign bus.ftdi_data_oe  = r_data_oe;
  assign bus.ftdi_siwu     = r_siwu;
endmodule

// File: tb/tb_ft245_sync_tx.sv
// Scoreboard bench for ft245_sync_tx: expected bus bytes are queued when a packet is requested
// and popped on every edge where the FTDI side accepts a byte.
module tb_ft245_sync_tx;
  localparam int CW = 24;

  logic ftdi_clk = 1'b0;
  logic rst;
  always #5 ftdi_clk = ~ftdi_clk;

  ft245_sync_tx_if #(.COUNT_WIDTH(CW)) bus ();

  ft245_sync_tx #(.COUNT_WIDTH(CW), .SEND_IMMEDIATE(1'b1)) dut (
    .ftdi_clk (ftdi_clk),
    .rst      (rst),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] feed_q[$];
  int          feed_dly[$];
  int          dly_cnt = 0;
  logic        took = 1'b0;
  int          exp_total = 0;
  int          st_edge = 0;

  int acc_cnt, first_acc, last_acc, siwu_cnt, siwu_cyc, done_cnt, done_cyc;
  int rdy_cnt, gap_wrhi, stall_cyc, stall_oe_bad, rx_bad;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_stats();
    acc_cnt = 0; first_acc = 0; last_acc = 0; siwu_cnt = 0; siwu_cyc = 0;
    done_cnt = 0; done_cyc = 0; rdy_cnt = 0; gap_wrhi = 0; stall_cyc = 0;
    stall_oe_bad = 0; rx_bad = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic feed(input logic [31:0] w, input int dly);
    feed_q.push_back(w);
    feed_dly.push_back(dly);
  endtask

  task automatic send(input logic [31:0] st, input logic [31:0] ad, input int cnt);
    @(posedge ftdi_clk); #1;
    push_word(st);
    push_word(ad);
    foreach (feed_q[i]) push_word(feed_q[i]);
    exp_total = exp_q.size();
    bus.status     = st;
    bus.address    = ad;
    bus.data_count = CW'(cnt);
    bus.start      = 1'b1;
    st_edge        = cyc + 1;
    @(posedge ftdi_clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge ftdi_clk); #1;
    end
    chk_val({tag, "_done_seen"}, done_cnt > 0, 1);
    @(posedge ftdi_clk); #1;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && acc_cnt < n; i++) begin
      @(posedge ftdi_clk); #1;
    end
    chk_val({tag, "_reached"}, acc_cnt >= n, 1);
  endtask

  // Monitor: outputs are stable here and the inputs are those the next edge will sample.
  initial forever begin
    @(negedge ftdi_clk);
    took = 1'b0;
    if (!rst) begin
      if (!bus.ftdi_wr_n && !bus.ftdi_txe_n) begin
        if (acc_cnt == 0) first_acc = cyc + 1;
        last_acc = cyc + 1;
        acc_cnt++;
        if (exp_q.size() == 0) chk_val("extra_byte", {24'h0, bus.ftdi_data_out}, 32'hxxxx_xxxx);
        else                   chk_val("byte", {24'h0, bus.ftdi_data_out}, {24'h0, exp_q.pop_front()});
      end
      if (bus.ftdi_txe_n && bus.ftdi_wr_n) gap_wrhi++;
      if (bus.busy && bus.ftdi_wr_n && !bus.ftdi_txe_n && acc_cnt > 0 && acc_cnt < exp_total) begin
        stall_cyc++;
        if (!bus.ftdi_data_oe) stall_oe_bad++;
      end
      if (bus.rx_active && (bus.ftdi_data_oe || !bus.ftdi_wr_n)) rx_bad++;
      if (!bus.ftdi_siwu) begin siwu_cnt++; siwu_cyc = cyc; end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.data_ready) rdy_cnt++;
      took = bus.data_valid && bus.data_ready;
    end
  end

  // Payload source: each word waits its delay counted in data_ready-high cycles.
  initial forever begin
    logic [31:0] tw;
    int          td;
    @(posedge ftdi_clk);
    cyc++;
    #1;
    if (rst) begin
      bus.data_valid = 1'b0;
      dly_cnt = 0;
    end else begin
      if (took && feed_q.size() > 0) begin
        bus.data_valid = 1'b0;
        tw = feed_q.pop_front();
        td = feed_dly.pop_front();
        dly_cnt = 0;
      end
      if (!bus.data_valid && feed_q.size() > 0) begin
        if (dly_cnt >= feed_dly[0]) begin
          bus.data_in    = feed_q[0];
          bus.data_valid = 1'b1;
        end else if (bus.data_ready) begin
          dly_cnt++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.status = '0; bus.address = '0; bus.data_count = '0;
    bus.data_in = '0; bus.data_valid = 1'b0; bus.rx_active = 1'b0; bus.ftdi_txe_n = 1'b0;
    clr_stats();
    repeat (3) @(posedge ftdi_clk);
    #1;
    chk_val("rst_wr_n",  bus.ftdi_wr_n, 1);
    chk_val("rst_oe",    bus.ftdi_data_oe, 0);
    chk_val("rst_siwu",  bus.ftdi_siwu, 1);
    chk_val("rst_done",  bus.done, 0);
    chk_val("rst_busy",  bus.busy, 0);
    chk_val("rst_ready", bus.data_ready, 0);
    rst = 1'b0;

    // Single word, free-flowing bus
    clr_stats();
    feed(32'h0123_4567, 0);
    send(32'hCD00_0001, 32'h0100_0000, 1);
    wait_done("t1", 200);
    chk_val("t1_bytes",   acc_cnt, 12);
    chk_val("t1_span",    last_acc - first_acc, 11);
    chk_val("t1_latency", first_acc - st_edge, 3);
    chk_val("t1_siwu",    siwu_cnt, 1);
    chk_val("t1_done",    done_cnt, 1);
    chk_val("t1_done_after_siwu", done_cyc - siwu_cyc, 1);
    chk_val("t1_busy",    bus.busy, 0);
    chk_val("t1_oe",      bus.ftdi_data_oe, 0);
    chk_val("t1_left",    exp_q.size(), 0);
    chk_val("t1_stall",   stall_cyc, 0);

    // Four-word burst with data_valid always high
    clr_stats();
    feed(32'h1111_1111, 0); feed(32'h2222_2222, 0);
    feed(32'h3333_3333, 0); feed(32'h4444_4444, 0);
    send(32'hA000_0004, 32'h0000_1000, 4);
    wait_done("t2", 300);
    chk_val("t2_bytes", acc_cnt, 24);
    chk_val("t2_span",  last_acc - first_acc, 23);
    chk_val("t2_ready", rdy_cnt, 4);
    chk_val("t2_left",  exp_q.size(), 0);

    // TX FIFO full for 3 cycles after the 5th byte
    clr_stats();
    feed(32'h0123_4567, 0);
    send(32'hCD00_0001, 32'h0100_0000, 1);
    wait_bytes("t3", 5, 100);
    bus.ftdi_txe_n = 1'b1;
    repeat (3) begin
      @(posedge ftdi_clk); #1;
    end
    bus.ftdi_txe_n = 1'b0;
    wait_done("t3", 200);
    chk_val("t3_gap_wr_n", gap_wrhi, 2);
    chk_val("t3_bytes",    acc_cnt, 12);
    chk_val("t3_left",     exp_q.size(), 0);

    // Payload underrun forces a stall with the bus still driven
    clr_stats();
    feed(32'hDEAD_BEEF, 0);
    feed(32'hCAFE_F00D, 6);
    send(32'h5000_0002, 32'h0000_2000, 2);
    wait_done("t4", 300);
    chk_val("t4_stalled",  stall_cyc > 0, 1);
    chk_val("t4_stall_oe", stall_oe_bad, 0);
    chk_val("t4_bytes",    acc_cnt, 16);
    chk_val("t4_left",     exp_q.size(), 0);

    // Receive path owns the bus; count 0 still sends one data word
    clr_stats();
    bus.rx_active = 1'b1;
    feed(32'h89AB_CDEF, 0);
    send(32'h7700_0000, 32'h0000_3000, 0);
    repeat (9) begin
      @(posedge ftdi_clk); #1;
    end
    chk_val("t5_wait_busy", bus.busy, 1);
    chk_val("t5_wait_oe",   bus.ftdi_data_oe, 0);
    chk_val("t5_wait_wr_n", bus.ftdi_wr_n, 1);
    bus.rx_active = 1'b0;
    wait_done("t5", 200);
    chk_val("t5_rx_clash", rx_bad, 0);
    chk_val("t5_bytes",    acc_cnt, 12);
    chk_val("t5_left",     exp_q.size(), 0);

    // Reset in the middle of a packet, then a fresh packet
    clr_stats();
    feed(32'h1234_5678, 0); feed(32'h9ABC_DEF0, 0);
    send(32'hEE00_0002, 32'h0000_4000, 2);
    wait_bytes("t6", 7, 100);
    rst = 1'b1;
    @(posedge ftdi_clk); #1;
    chk_val("t6_rst_wr_n",  bus.ftdi_wr_n, 1);
    chk_val("t6_rst_oe",    bus.ftdi_data_oe, 0);
    chk_val("t6_rst_busy",  bus.busy, 0);
    chk_val("t6_rst_ready", bus.data_ready, 0);
    exp_q.delete();
    feed_q.delete();
    feed_dly.delete();
    @(posedge ftdi_clk); #1;
    rst = 1'b0;
    clr_stats();
    feed(32'h0BAD_CAFE, 0);
    send(32'h3300_0001, 32'h0000_5000, 1);
    wait_done("t6", 200);
    chk_val("t6_bytes", acc_cnt, 12);
    chk_val("t6_span",  last_acc - first_acc, 11);
    chk_val("t6_left",  exp_q.size(), 0);
    chk_val("t6_busy",  bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
